// File: rtl/lb_demo_regs_pkg.sv
// rtl/lb_demo_regs_pkg.sv - shared region codes, register offsets and ID words
package lb_demo_regs_pkg;

  localparam logic [3:0] REGION_CTRL  = 4'd0;
  localparam logic [3:0] REGION_RXMAC = 4'd2;

  localparam logic [3:0] OFF_ID0        = 4'h0;
  localparam logic [3:0] OFF_ID1        = 4'h1;
  localparam logic [3:0] OFF_ID2        = 4'h2;
  localparam logic [3:0] OFF_ID3        = 4'h3;
  localparam logic [3:0] OFF_STATUS     = 4'h4;
  localparam logic [3:0] OFF_SCRATCH_IN = 4'h5;
  localparam logic [3:0] OFF_BADGE_CNT  = 4'h6;
  localparam logic [3:0] OFF_LAST_BADGE = 4'h7;
  localparam logic [3:0] OFF_SCRATCH    = 4'h8;
  localparam logic [3:0] OFF_LEDS       = 4'h9;
  localparam logic [3:0] OFF_STOP       = 4'hA;

  // "Hello world!\r\n\r\n"
  localparam logic [31:0] ID_WORD0 = 32'h48656c6c;
  localparam logic [31:0] ID_WORD1 = 32'h6f20776f;
  localparam logic [31:0] ID_WORD2 = 32'h726c6421;
  localparam logic [31:0] ID_WORD3 = 32'h0d0a0d0a;

  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_CTRL,
    SRC_RXMAC
  } rd_src_t;

endpackage

// File: rtl/activity_stretch.sv
// rtl/activity_stretch.sv - holds led high for 2^cw-1 cycles after the last trigger
module activity_stretch #(
  parameter int cw = 22
) (
  input  logic clk,
  input  logic rst,
  input  logic trigger,
  output logic led
);

  logic [cw-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (trigger) begin
      cnt <= '1;
    end else if (cnt != '0) begin
      cnt <= cnt - cw'(1);
    end
  end

  assign led = (cnt != '0);

endmodule

// File: rtl/lb_demo_regs.sv
// rtl/lb_demo_regs.sv - local-bus demo register slave with badge counters and Rx MAC read-back
module lb_demo_regs
  import lb_demo_regs_pkg::*;
#(
  parameter int act_cw = 22
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] addr,
  input  logic        control_strobe,
  input  logic        control_rd,
  input  logic [31:0] data_out,
  output logic [31:0] data_in,
  input  logic        ibadge_stb,
  input  logic [7:0]  ibadge_data,
  input  logic        obadge_stb,
  input  logic [7:0]  obadge_data,
  input  logic        xdomain_fault,
  input  logic [31:0] scratch_in,
  input  logic        tx_mac_done,
  input  logic [15:0] rx_mac_data,
  input  logic [1:0]  rx_mac_buf_status,
  input  logic        rx_mac_hbank,
  output logic        led_user_mode,
  output logic        led1,
  output logic        led2,
  output logic        act_led,
  output logic        stop_sim
);

  logic        rd_stb, wr_stb;
  logic [3:0]  region, offset;
  logic [31:0] scratch;
  logic [15:0] ibadge_cnt, obadge_cnt, txdone_cnt;
  logic [7:0]  last_ibadge, last_obadge;
  rd_src_t     rd_src, src_p1;
  logic        rd_p1;
  logic [31:0] ctrl_word, ctrl_word_p1;
  logic [15:0] rx_data_p1;
  logic        unused_addr;

  assign rd_stb      = control_strobe & control_rd;
  assign wr_stb      = control_strobe & ~control_rd;
  assign region      = addr[23:20];
  assign offset      = addr[3:0];
  assign unused_addr = ^addr[19:4];

  always_comb begin
    rd_src = SRC_ZERO;
    if (region == REGION_CTRL) begin
      rd_src = SRC_CTRL;
    end else if (region == REGION_RXMAC) begin
      rd_src = SRC_RXMAC;
    end
  end

  // Snapshot taken at the strobe so coincident counter events read pre-increment
  always_comb begin
    ctrl_word = '0;
    case (offset)
      OFF_ID0:        ctrl_word = ID_WORD0;
      OFF_ID1:        ctrl_word = ID_WORD1;
      OFF_ID2:        ctrl_word = ID_WORD2;
      OFF_ID3:        ctrl_word = ID_WORD3;
      OFF_STATUS:     ctrl_word = {28'b0, rx_mac_hbank, rx_mac_buf_status, xdomain_fault};
      OFF_SCRATCH_IN: ctrl_word = scratch_in;
      OFF_BADGE_CNT:  ctrl_word = {ibadge_cnt, obadge_cnt};
      OFF_LAST_BADGE: ctrl_word = {last_ibadge, last_obadge, txdone_cnt};
      OFF_SCRATCH:    ctrl_word = scratch;
      OFF_LEDS:       ctrl_word = {29'b0, led_user_mode, led2, led1};
      default:        ctrl_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_p1         <= 1'b0;
      src_p1        <= SRC_ZERO;
      ctrl_word_p1  <= '0;
      rx_data_p1    <= '0;
      data_in       <= '0;
      scratch       <= '0;
      led1          <= 1'b0;
      led2          <= 1'b0;
      led_user_mode <= 1'b0;
      stop_sim      <= 1'b0;
      ibadge_cnt    <= '0;
      obadge_cnt    <= '0;
      txdone_cnt    <= '0;
      last_ibadge   <= '0;
      last_obadge   <= '0;
    end else begin
      rd_p1 <= rd_stb;
      if (rd_stb) begin
        src_p1       <= rd_src;
        ctrl_word_p1 <= ctrl_word;
        rx_data_p1   <= rx_mac_data;
      end
      if (rd_p1) begin
        case (src_p1)
          SRC_CTRL:  data_in <= ctrl_word_p1;
          SRC_RXMAC: data_in <= {16'b0, rx_data_p1};
          default:   data_in <= '0;
        endcase
      end
      if (wr_stb && region == REGION_CTRL) begin
        case (offset)
          OFF_SCRATCH: scratch <= data_out;
          OFF_LEDS: begin
            led1          <= data_out[0];
            led2          <= data_out[1];
            led_user_mode <= data_out[2];
          end
          OFF_STOP: stop_sim <= 1'b1;
          default: ;
        endcase
      end
      if (ibadge_stb) begin
        ibadge_cnt  <= ibadge_cnt + 16'd1;
        last_ibadge <= ibadge_data;
      end
      if (obadge_stb) begin
        obadge_cnt  <= obadge_cnt + 16'd1;
        last_obadge <= obadge_data;
      end
      if (tx_mac_done) begin
        txdone_cnt <= txdone_cnt + 16'd1;
      end
    end
  end

  activity_stretch #(.cw(act_cw)) u_act (
    .clk     (clk),
    .rst     (rst),
    .trigger (ibadge_stb | obadge_stb),
    .led     (act_led)
  );

endmodule

// File: tb/tb_lb_demo_regs.sv
// tb/tb_lb_demo_regs.sv - self-checking bench for lb_demo_regs against a behavioural model
module tb_lb_demo_regs;

  localparam int CW = 3;
  localparam int HOLD = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] addr = '0;
  logic        control_strobe = 1'b0;
  logic        control_rd = 1'b0;
  logic [31:0] data_out = '0;
  logic [31:0] data_in;
  logic        ibadge_stb = 1'b0;
  logic [7:0]  ibadge_data = '0;
  logic        obadge_stb = 1'b0;
  logic [7:0]  obadge_data = '0;
  logic        xdomain_fault = 1'b0;
  logic [31:0] scratch_in = 32'h1357_9bdf;
  logic        tx_mac_done = 1'b0;
  logic [15:0] rx_mac_data = '0;
  logic [1:0]  rx_mac_buf_status = '0;
  logic        rx_mac_hbank = 1'b0;
  logic        led_user_mode, led1, led2, act_led, stop_sim;

  always #5 clk = ~clk;

  lb_demo_regs #(.act_cw(CW)) dut (
    .clk               (clk),
    .rst               (rst),
    .addr              (addr),
    .control_strobe    (control_strobe),
    .control_rd        (control_rd),
    .data_out          (data_out),
    .data_in           (data_in),
    .ibadge_stb        (ibadge_stb),
    .ibadge_data       (ibadge_data),
    .obadge_stb        (obadge_stb),
    .obadge_data       (obadge_data),
    .xdomain_fault     (xdomain_fault),
    .scratch_in        (scratch_in),
    .tx_mac_done       (tx_mac_done),
    .rx_mac_data       (rx_mac_data),
    .rx_mac_buf_status (rx_mac_buf_status),
    .rx_mac_hbank      (rx_mac_hbank),
    .led_user_mode     (led_user_mode),
    .led1              (led1),
    .led2              (led2),
    .act_led           (act_led),
    .stop_sim          (stop_sim)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model
  typedef struct {
    logic [31:0] v;
    int          due;
  } rd_t;

  rd_t         rd_q[$];
  int          cyc = 0;
  logic [31:0] m_data = '0;
  logic [31:0] m_scratch = '0;
  logic        m_led1 = 0, m_led2 = 0, m_user = 0, m_stop = 0;
  int          m_icnt = 0, m_ocnt = 0, m_tcnt = 0;
  logic [7:0]  m_lib = '0, m_lob = '0;
  int          m_since = 1000;
  string       id_str = "Hello world!\r\n\r\n";

  function automatic logic [31:0] id_word(input int w);
    return {id_str[4*w], id_str[4*w+1], id_str[4*w+2], id_str[4*w+3]};
  endfunction

  function automatic logic [31:0] model_read(input logic [23:0] a);
    if (a[23:20] == 4'd2) return {16'b0, rx_mac_data};
    if (a[23:20] != 4'd0) return 32'h0;
    case (a[3:0])
      4'h0, 4'h1, 4'h2, 4'h3: return id_word(int'(a[1:0]));
      4'h4: return {28'b0, rx_mac_hbank, rx_mac_buf_status, xdomain_fault};
      4'h5: return scratch_in;
      4'h6: return {m_icnt[15:0], m_ocnt[15:0]};
      4'h7: return {m_lib, m_lob, m_tcnt[15:0]};
      4'h8: return m_scratch;
      4'h9: return {29'b0, m_user, m_led2, m_led1};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      rd_q.delete();
      m_data = '0; m_scratch = '0;
      m_led1 = 0; m_led2 = 0; m_user = 0; m_stop = 0;
      m_icnt = 0; m_ocnt = 0; m_tcnt = 0; m_lib = '0; m_lob = '0;
      m_since = 1000;
    end else begin
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
        m_data = rd_q[0].v;
        void'(rd_q.pop_front());
      end
      if (control_strobe && control_rd) rd_q.push_back('{model_read(addr), cyc + 1});
      if (control_strobe && !control_rd && addr[23:20] == 4'd0) begin
        if (addr[3:0] == 4'h8) m_scratch = data_out;
        if (addr[3:0] == 4'h9) begin
          m_led1 = data_out[0]; m_led2 = data_out[1]; m_user = data_out[2];
        end
        if (addr[3:0] == 4'hA) m_stop = 1;
      end
      if (ibadge_stb) begin m_icnt = (m_icnt + 1) % 65536; m_lib = ibadge_data; end
      if (obadge_stb) begin m_ocnt = (m_ocnt + 1) % 65536; m_lob = obadge_data; end
      if (tx_mac_done) m_tcnt = (m_tcnt + 1) % 65536;
      if (ibadge_stb || obadge_stb) m_since = 0;
      else if (m_since < 1000) m_since++;
    end
  end

  bit chk_en = 0;
  int act_hi = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("data_in", data_in, m_data);
      check("led1", 32'(led1), 32'(m_led1));
      check("led2", 32'(led2), 32'(m_led2));
      check("led_user_mode", 32'(led_user_mode), 32'(m_user));
      check("stop_sim", 32'(stop_sim), 32'(m_stop));
      check("act_led", 32'(act_led), 32'(m_since < HOLD));
      if (act_led) act_hi++;
    end
  end

  // All tasks start and end at #1 after a rising edge
  task automatic do_write(input logic [23:0] a, input logic [31:0] d);
    addr = a; data_out = d; control_rd = 1'b0; control_strobe = 1'b1;
    @(posedge clk); #1;
    control_strobe = 1'b0;
  endtask

  task automatic do_read(input logic [23:0] a, input logic [31:0] exp, input string name);
    addr = a; control_rd = 1'b1; control_strobe = 1'b1;
    @(posedge clk); #1;
    control_strobe = 1'b0;
    @(posedge clk); #1;
    check(name, data_in, exp);
  endtask

  task automatic pulse_i(input logic [7:0] d);
    ibadge_stb = 1'b1; ibadge_data = d;
    @(posedge clk); #1;
    ibadge_stb = 1'b0;
  endtask

  task automatic pulse_o(input logic [7:0] d);
    obadge_stb = 1'b1; obadge_data = d;
    @(posedge clk); #1;
    obadge_stb = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1;

    check("reset_data_in", data_in, 32'h0);
    check("reset_stop", 32'(stop_sim), 32'h0);
    check("model_id0", id_word(0), 32'h48656c6c);

    do_read(24'h000000, 32'h48656c6c, "id0");
    do_read(24'h000001, 32'h6f20776f, "id1");
    do_read(24'h000002, 32'h726c6421, "id2");
    do_read(24'h000003, 32'h0d0a0d0a, "id3");

    do_write(24'h000008, 32'hA5A5_1234);
    do_read(24'h000008, 32'hA5A51234, "scratch_b2b");
    do_write(24'h000009, 32'h5);
    do_read(24'h000009, 32'h5, "leds_rd");
    check("led1_lit", 32'(led1), 32'h1);
    check("led2_lit", 32'(led2), 32'h0);
    check("user_lit", 32'(led_user_mode), 32'h1);
    do_write(24'h100008, 32'hFFFF_FFFF);
    do_read(24'h000008, 32'hA5A51234, "wr_other_region");
    do_read(24'h000005, 32'h13579bdf, "scratch_in");

    pulse_i(8'h11); pulse_i(8'h22); pulse_i(8'h33); pulse_o(8'h44);
    tx_mac_done = 1'b1; @(posedge clk); #1; tx_mac_done = 1'b0;
    do_read(24'h000006, 32'h00030001, "badge_cnt");
    do_read(24'h000007, 32'h33440001, "last_badge");

    // counter event coincident with the read strobe
    ibadge_stb = 1'b1; ibadge_data = 8'h55;
    addr = 24'h000006; control_rd = 1'b1; control_strobe = 1'b1;
    @(posedge clk); #1;
    ibadge_stb = 1'b0; control_strobe = 1'b0;
    @(posedge clk); #1;
    check("cnt_pre_inc", data_in, 32'h00030001);
    do_read(24'h000006, 32'h00040001, "cnt_post_inc");

    rx_mac_data = 16'hBEEF;
    do_read(24'h200123, 32'h0000BEEF, "rxmac");
    rx_mac_hbank = 1'b1; rx_mac_buf_status = 2'b10; xdomain_fault = 1'b1;
    do_read(24'h000004, 32'hD, "status");
    do_read(24'h300000, 32'h0, "other_region");
    do_read(24'h00000B, 32'h0, "unmapped");

    // reset while a read is in flight
    do_read(24'h000009, 32'h5, "leds_pre_flush");
    addr = 24'h000000; control_rd = 1'b1; control_strobe = 1'b1;
    @(posedge clk); #1;
    control_strobe = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("flush", data_in, 32'h0);
    idle(2);
    check("flush_hold", data_in, 32'h0);

    idle(10);
    act_hi = 0;
    pulse_i(8'h66);
    idle(12);
    check("act_single", 32'(act_hi), 32'(HOLD));
    act_hi = 0;
    pulse_i(8'h77);
    idle(2);
    pulse_o(8'h88);
    idle(14);
    check("act_extend", 32'(act_hi), 32'd10);

    do_write(24'h000008, 32'hDEAD_BEEF);
    do_write(24'h000009, 32'h7);
    do_write(24'h00000A, 32'h0);
    check("stop_set", 32'(stop_sim), 32'h1);
    idle(3);
    check("stop_sticky", 32'(stop_sim), 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("stop_rst", 32'(stop_sim), 32'h0);
    check("leds_rst", {29'b0, led_user_mode, led2, led1}, 32'h0);
    do_read(24'h000008, 32'h0, "scratch_rst");
    do_read(24'h000006, 32'h0, "cnt_rst");

    idle(3);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
